// File: rtl/pc_pkg.sv
// pc_pkg: shared constants for the program-counter slice.
//   OP_*        one-hot-free operation codes produced by the pc_unit priority decoder
//   cnt_width   bits needed to hold a stack occupancy of 0..depth
//   idx_width   bits needed to address depth stack entries
package pc_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NONE   = 3'd0;
  localparam logic [OP_W-1:0] OP_INCR   = 3'd1;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'd2;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'd3;
  localparam logic [OP_W-1:0] OP_CALL   = 3'd4;
  localparam logic [OP_W-1:0] OP_RET    = 3'd5;

  // clog2(depth+1): width of a counter that must reach depth itself
  function automatic int unsigned cnt_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < (depth + 32'd1)) w = w + 1;
    return w;
  endfunction

  // Address width for depth entries, never below one bit
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? cnt_width(depth - 1) : 1;
  endfunction

endpackage

// File: rtl/pc_if.sv
// pc_if: request/response bundle between the fetch stage and pc_unit.
//   master: drives incr/load/load_addr/branch/offset/call/ret, observes PC and flags
//   slave : pc_unit side
interface pc_if #(
  parameter int unsigned SIZE = 8
);

  logic            incr;
  logic            load;
  logic [SIZE-1:0] load_addr;
  logic            branch;
  logic [SIZE-1:0] offset;
  logic            call;
  logic            ret;
  logic [SIZE-1:0] out;
  logic            stack_empty;
  logic            stack_full;
  logic            err;

  modport master (
    output incr, load, load_addr, branch, offset, call, ret,
    input  out, stack_empty, stack_full, err
  );

  modport slave (
    input  incr, load, load_addr, branch, offset, call, ret,
    output out, stack_empty, stack_full, err
  );

endinterface

// File: rtl/pc_stack.sv
// pc_stack: LIFO of return addresses.
//   clk, reset    clock, asynchronous active-high reset (clears occupancy only)
//   push, pop     push on full and pop on empty are ignored; pop wins if both
//   din           value pushed
//   dout          current top of stack (combinational, meaningless when empty)
//   empty, full   registered occupancy flags
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned IW = idx_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & ~pop & ~full;

  // Occupancy and flags; flags are computed from the next count so they
  // land in the same cycle as the count change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else if (do_push) begin
      count <= count + CW'(1);
      empty <= 1'b0;
      full  <= (count == CW'(DEPTH - 1));
    end else if (do_pop) begin
      count <= count - CW'(1);
      empty <= (count == CW'(1));
      full  <= 1'b0;
    end
  end

  // Storage carries no reset; only occupancy defines validity
  always_ff @(posedge clk) begin
    if (do_push) mem[IW'(count)] <= din;
  end

  assign dout = mem[IW'(count - CW'(1))];

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with load, relative branch,
// call/return through an internal return stack, and edge/level increment.
//   clk, reset   clock, asynchronous active-high reset
//   bus (slave)  incr/load/load_addr/branch/offset/call/ret requests in;
//                out (PC), stack_empty, stack_full, err (sticky) out
// One operation per cycle, priority ret > call > load > branch > incr.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned SIZE        = 8,
  parameter int unsigned STEP        = 1,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned EDGE_MODE   = 1
) (
  input  logic clk,
  input  logic reset,
  pc_if.slave  bus
);

  logic [SIZE-1:0] pc_q;
  logic [SIZE-1:0] pc_nxt;
  logic [SIZE-1:0] ret_addr;
  logic [SIZE-1:0] top;
  logic            err_q;
  logic            err_nxt;
  logic            incr_q;
  logic            incr_evt;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  logic [OP_W-1:0] op;

  // incr_q tracks incr every cycle, even when another op wins
  assign incr_evt = (EDGE_MODE != 0) ? (bus.incr & ~incr_q) : bus.incr;
  assign ret_addr = pc_q + SIZE'(STEP);

  // Priority decode; losing requests are dropped
  always_comb begin
    op = OP_NONE;
    if (bus.ret)         op = OP_RET;
    else if (bus.call)   op = OP_CALL;
    else if (bus.load)   op = OP_LOAD;
    else if (bus.branch) op = OP_BRANCH;
    else if (incr_evt)   op = OP_INCR;
  end

  // Next-PC mux, stack control and error detection
  always_comb begin
    pc_nxt  = pc_q;
    err_nxt = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (op)
      OP_RET: begin
        if (empty) begin
          err_nxt = 1'b1;
        end else begin
          pop    = 1'b1;
          pc_nxt = top;
        end
      end
      OP_CALL: begin
        if (full) begin
          err_nxt = 1'b1;
        end else begin
          push   = 1'b1;
          pc_nxt = bus.load_addr;
        end
      end
      OP_LOAD:   pc_nxt = bus.load_addr;
      OP_BRANCH: pc_nxt = pc_q + bus.offset;
      OP_INCR:   pc_nxt = ret_addr;
      default:   ;
    endcase
  end

  // PC, sticky error and edge-detector state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      err_q  <= 1'b0;
      incr_q <= 1'b0;
    end else begin
      pc_q   <= pc_nxt;
      err_q  <= err_nxt;
      incr_q <= bus.incr;
    end
  end

  pc_stack #(
    .WIDTH (SIZE),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .dout  (top),
    .empty (empty),
    .full  (full)
  );

  assign bus.out         = pc_q;
  assign bus.err         = err_q;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit. dut_e: STEP=1, edge incr;
// dut_l: STEP=2, level incr. Stimulus pushes expected PC/flags; a monitor
// pops and compares after each rising edge or on an explicit async check.
module tb_pc_unit;

  typedef struct packed {
    logic       d;    // 0: dut_e, 1: dut_l
    logic [7:0] out;
    logic [2:0] fl;   // {empty, full, err}
  } exp_t;

  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] IN = 5'b00001;
  localparam logic [4:0] BR = 5'b00010;
  localparam logic [4:0] LD = 5'b00100;
  localparam logic [4:0] CA = 5'b01000;
  localparam logic [4:0] RE = 5'b10000;
  localparam logic [2:0] E  = 3'b100;
  localparam logic [2:0] F  = 3'b010;
  localparam logic [2:0] R  = 3'b001;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  event chk_now;
  exp_t  sb[$];
  string nm_q[$];

  pc_if #(.SIZE(8)) bus_e ();
  pc_if #(.SIZE(8)) bus_l ();

  pc_unit #(.SIZE(8), .STEP(1), .STACK_DEPTH(4), .EDGE_MODE(1)) dut_e (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_e)
  );

  pc_unit #(.SIZE(8), .STEP(2), .STACK_DEPTH(4), .EDGE_MODE(0)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic d, input logic [4:0] ops, input logic [7:0] a, input logic [7:0] o);
    logic [4:0] oe;
    logic [4:0] ol;
    oe = d ? NO : ops;
    ol = d ? ops : NO;
    {bus_e.ret, bus_e.call, bus_e.load, bus_e.branch, bus_e.incr} = oe;
    {bus_l.ret, bus_l.call, bus_l.load, bus_l.branch, bus_l.incr} = ol;
    bus_e.load_addr = a;
    bus_e.offset    = o;
    bus_l.load_addr = a;
    bus_l.offset    = o;
  endtask

  task automatic expect_pc(input logic d, input string nm, input logic [7:0] xo, input logic [2:0] xf);
    exp_t x;
    x.d   = d;
    x.out = xo;
    x.fl  = xf;
    sb.push_back(x);
    nm_q.push_back(nm);
  endtask

  // One clocked cycle: drive at negedge, expect result after the next posedge
  task automatic step(input logic d, input logic [4:0] ops, input logic [7:0] a, input logic [7:0] o,
                      input string nm, input logic [7:0] xo, input logic [2:0] xf);
    drive(d, ops, a, o);
    expect_pc(d, nm, xo, xf);
    @(negedge clk);
  endtask

  // Monitor: one pop per posedge (+1) or per explicit check event
  initial begin
    exp_t       x;
    string      nm;
    logic [7:0] ao;
    logic [2:0] af;
    forever begin
      @(posedge clk or chk_now);
      #1;
      if (sb.size() != 0) begin
        x  = sb.pop_front();
        nm = nm_q.pop_front();
        if (x.d) begin
          ao = bus_l.out;
          af = {bus_l.stack_empty, bus_l.stack_full, bus_l.err};
        end else begin
          ao = bus_e.out;
          af = {bus_e.stack_empty, bus_e.stack_full, bus_e.err};
        end
        n_cmp++;
        if ({ao, af} !== {x.out, x.fl}) begin
          n_bad++;
          $display("FAIL %s: got out=%h empty/full/err=%b, expected out=%h empty/full/err=%b",
                   nm, ao, af, x.out, x.fl);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(1'b0, NO, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    step(0, NO, 8'h00, 8'h00, "reset_idle", 8'h00, E);

    // Level-mode DUT, STEP=2: wrap from FE, then call/ret return address
    step(1, LD, 8'hFE, 8'h00, "l_load",       8'hFE, E);
    step(1, IN, 8'h00, 8'h00, "l_incr_wrap",  8'h00, E);
    step(1, IN, 8'h00, 8'h00, "l_incr_level", 8'h02, E);
    step(1, NO, 8'h00, 8'h00, "l_hold",       8'h02, E);
    step(1, CA, 8'h10, 8'h00, "l_call",       8'h10, 3'b000);
    step(1, RE, 8'h00, 8'h00, "l_ret",        8'h04, E);

    // Edge mode: held incr counts once, pulses count each
    for (int i = 0; i < 5; i++) step(0, IN, 8'h00, 8'h00, "e_incr_held", 8'h01, E);
    step(0, NO, 8'h00, 8'h00, "e_release", 8'h01, E);
    for (int i = 0; i < 3; i++) begin
      step(0, IN, 8'h00, 8'h00, "e_pulse_hi", 8'(8'h02 + i), E);
      step(0, NO, 8'h00, 8'h00, "e_pulse_lo", 8'(8'h02 + i), E);
    end

    // Branches with wrap, incr wrap
    step(0, LD, 8'h10, 8'h00, "br_load10",   8'h10, E);
    step(0, BR, 8'h00, 8'hF0, "br_minus16",  8'h00, E);
    step(0, BR, 8'h00, 8'h05, "br_plus5",    8'h05, E);
    step(0, LD, 8'h00, 8'h00, "br_load00",   8'h00, E);
    step(0, BR, 8'h00, 8'hFF, "br_minus1",   8'hFF, E);
    step(0, IN, 8'h00, 8'h00, "incr_wrap",   8'h00, E);
    step(0, NO, 8'h00, 8'h00, "incr_lo",     8'h00, E);

    // Single call/ret
    step(0, LD, 8'h20, 8'h00, "cr_load20", 8'h20, E);
    step(0, CA, 8'h80, 8'h00, "cr_call",   8'h80, 3'b000);
    step(0, RE, 8'h00, 8'h00, "cr_ret",    8'h21, E);

    // Fill, overflow, unwind, underflow
    step(0, CA, 8'h50, 8'h00, "fill_1",    8'h50, 3'b000);
    step(0, CA, 8'h60, 8'h00, "fill_2",    8'h60, 3'b000);
    step(0, CA, 8'h70, 8'h00, "fill_3",    8'h70, 3'b000);
    step(0, CA, 8'h80, 8'h00, "fill_4",    8'h80, F);
    step(0, CA, 8'h90, 8'h00, "overflow",  8'h80, F | R);
    step(0, RE, 8'h00, 8'h00, "unwind_1",  8'h71, R);
    step(0, RE, 8'h00, 8'h00, "unwind_2",  8'h61, R);
    step(0, RE, 8'h00, 8'h00, "unwind_3",  8'h51, R);
    step(0, RE, 8'h00, 8'h00, "unwind_4",  8'h22, E | R);
    step(0, RE, 8'h00, 8'h00, "underflow", 8'h22, E | R);

    // Priority, then async reset with two entries on the stack
    step(0, CA, 8'h30, 8'h00, "pr_call1",  8'h30, R);
    step(0, CA, 8'h40, 8'h00, "pr_call2",  8'h40, R);
    step(0, RE | CA | IN, 8'hAA, 8'h00, "pr_ret_wins", 8'h31, R);
    step(0, CA, 8'h50, 8'h00, "pr_call3",  8'h50, R);

    drive(1'b0, NO, 8'h00, 8'h00);
    #2 reset = 1'b1;
    expect_pc(0, "async_reset_e", 8'h00, E);
    -> chk_now;
    #2;
    expect_pc(1, "async_reset_l", 8'h00, E);
    -> chk_now;
    @(negedge clk);
    reset = 1'b0;
    step(0, NO, 8'h00, 8'h00, "post_reset_idle", 8'h00, E);
    step(0, IN, 8'h00, 8'h00, "post_reset_incr", 8'h01, E);
    step(0, NO, 8'h00, 8'h00, "post_reset_lo",   8'h01, E);

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
